// File: rtl/fetch_decode_fsm.sv
// Instruction fetch/decode/dispatch sequencer with a retired-instruction counter.
// Latency: FETCH, WAIT_MEM, DECODE, DISPATCH, then at least two EXEC_WAIT cycles; memory and unit time add to this.
// Backpressure: stalls in WAIT_MEM until memReady and in EXEC_WAIT until the selected unit reports done.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   run                           level; allows IDLE -> FETCH and FETCH after retire
//   memRead / memReady / memData  instruction memory request, data-valid, 16-bit word
//   opcode / param1 / param2      latched fields of the current instruction word
//   aluActivate..brActivate       one-cycle dispatch pulse to the selected execution unit
//   aluDone..brDone               level done flags from the execution units
//   halted                        HALT opcode reached; held until reset
//   fault                         execution timeout (only with EXEC_TIMEOUT_EN, else tied 0)
//   instrCount                    saturating retired-instruction count
//
// Build option: define EXEC_TIMEOUT_EN to add an 8-bit execution timeout that
// moves the FSM into FAULT when a unit takes 255 EXEC_WAIT cycles without done.

module fetch_decode_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        memRead,
    input  logic        memReady,
    input  logic [15:0] memData,
    output logic [3:0]  opcode,
    output logic [5:0]  param1,
    output logic [5:0]  param2,
    output logic        aluActivate,
    output logic        ldActivate,
    output logic        stActivate,
    output logic        brActivate,
    input  logic        aluDone,
    input  logic        ldDone,
    input  logic        stDone,
    input  logic        brDone,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instrCount
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_MEM  = 3'd2,
        DECODE    = 3'd3,
        DISPATCH  = 3'd4,
        EXEC_WAIT = 3'd5,
        HALT      = 3'd6,
        FAULT     = 3'd7
    } state_t;

    // Execution unit select, one-hot: bit0 ALU, bit1 load, bit2 store, bit3 branch.
    localparam logic [3:0] UNIT_ALU = 4'b0001;
    localparam logic [3:0] UNIT_LD  = 4'b0010;
    localparam logic [3:0] UNIT_ST  = 4'b0100;
    localparam logic [3:0] UNIT_BR  = 4'b1000;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  unit_q, unit_d;
    logic        first_q, first_d;
    logic [15:0] count_q, count_d;
`ifdef EXEC_TIMEOUT_EN
    logic [7:0]  tmo_q, tmo_d;
`endif

    logic [3:0]  done_vec;
    logic        sel_done;

    // Only the done line of the dispatched unit is ever looked at.
    assign done_vec = {brDone, stDone, ldDone, aluDone};
    assign sel_done = |(done_vec & unit_q);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unit_d  = unit_q;
        first_d = first_q;
        count_d = count_q;
`ifdef EXEC_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (memReady) begin
                    ir_d    = memData;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = DISPATCH;
                case (ir_q[15:12])
                    4'hC:    unit_d = UNIT_LD;
                    4'hD:    unit_d = UNIT_ST;
                    4'hE:    unit_d = UNIT_BR;
                    4'hF: begin
                        unit_d  = 4'b0000;
                        state_d = HALT;
                    end
                    default: unit_d = UNIT_ALU;
                endcase
            end
            DISPATCH: begin
                first_d = 1'b1;
                state_d = EXEC_WAIT;
`ifdef EXEC_TIMEOUT_EN
                tmo_d   = 8'd0;
`endif
            end
            EXEC_WAIT: begin
                // The unit's done may still be high from its previous job in
                // the first cycle after the pulse, so that cycle never retires.
                first_d = 1'b0;
                if (!first_q && sel_done) begin
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    state_d = run ? FETCH : IDLE;
                end
`ifdef EXEC_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q == 8'd254) begin
                        state_d = FAULT;
                    end
                end
`endif
            end
            HALT: begin
                state_d = HALT;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= 16'h0000;
            unit_q  <= 4'b0000;
            first_q <= 1'b0;
            count_q <= 16'h0000;
`ifdef EXEC_TIMEOUT_EN
            tmo_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            unit_q  <= unit_d;
            first_q <= first_d;
            count_q <= count_d;
`ifdef EXEC_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    assign memRead     = (state_q == FETCH) || (state_q == WAIT_MEM);
    assign aluActivate = (state_q == DISPATCH) && unit_q[0];
    assign ldActivate  = (state_q == DISPATCH) && unit_q[1];
    assign stActivate  = (state_q == DISPATCH) && unit_q[2];
    assign brActivate  = (state_q == DISPATCH) && unit_q[3];
    assign halted      = (state_q == HALT);
`ifdef EXEC_TIMEOUT_EN
    assign fault       = (state_q == FAULT);
`else
    assign fault       = 1'b0;
`endif
    assign opcode      = ir_q[15:12];
    assign param1      = ir_q[11:6];
    assign param2      = ir_q[5:0];
    assign instrCount  = count_q;

endmodule

// File: doc/fetch_decode_fsm.md
FETCH_DECODE_FSM -- requirements
Module: fetch_decode_fsm

Interface
REQ-001 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port run  in  1  level; permits leaving IDLE to fetch.
REQ-004 SHALL have port memRead  out  1  instruction-memory read request, PC on address bus.
REQ-005 SHALL have port memReady  in  1  memory data valid on memData this cycle.
REQ-006 SHALL have port memData  in  16  instruction word {opcode[15:12], param1[11:6], param2[5:0]}.
REQ-007 SHALL have ports opcode/param1/param2  out  4/6/6  latched instruction fields, stable from DECODE until next FETCH.
REQ-008 SHALL have ports aluActivate, ldActivate, stActivate, brActivate  out  1 each  one-cycle dispatch pulses.
REQ-009 SHALL have ports aluDone, ldDone, stDone, brDone  in  1 each  level done from execution FSMs.
REQ-010 SHALL have port halted  out  1  HALT reached.
REQ-011 SHALL have port fault  out  1  execution timeout (EXEC_TIMEOUT_EN only; else constant 0).
REQ-012 SHALL have port instrCount  out  16  retired-instruction count.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_MEM, DECODE, DISPATCH, EXEC_WAIT, HALT, FAULT.
REQ-014 IDLE: go to FETCH when run=1; otherwise stay.
REQ-015 FETCH: memRead=1 for one cycle; next WAIT_MEM.
REQ-016 WAIT_MEM: memRead held 1; on memReady=1 latch memData into instruction register, go DECODE; wait indefinitely otherwise.
REQ-017 DECODE (one cycle): opcode 0000-1011 -> ALU class; 1100 -> load; 1101 -> store; 1110 -> branch; 1111 -> HALT state directly, no dispatch.
REQ-018 DISPATCH: assert exactly one activate pulse, matching class, for exactly one cycle; next EXEC_WAIT.
REQ-019 EXEC_WAIT: ignore done of selected unit in first cycle after pulse (unit's stale done); from second cycle on, selected done=1 -> increment instrCount, go FETCH if run=1 else IDLE.
REQ-020 Done inputs of non-selected units SHALL be ignored in all states.
REQ-021 instrCount SHALL saturate at 16'hFFFF, never wrap.
REQ-022 HALT: halted=1, all activates 0, memRead 0; remain until rst; HALT itself not counted.
REQ-023 Dispatch-to-fetch: next FETCH exactly one cycle after done accepted; minimum instruction time = 5 cycles + memory wait + unit time.
REQ-024 run deasserted mid-instruction SHALL NOT abort; current instruction completes, then IDLE.
REQ-025 memReady outside WAIT_MEM SHALL be ignored.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, memRead=0, all activates 0, halted=0, fault=0, instrCount=0, opcode/param1/param2=0, timeout counter=0, regardless of clock.
REQ-027 rst asserted during EXEC_WAIT or WAIT_MEM SHALL abandon the instruction without counting it.

Configuration
REQ-028 Macro EXEC_TIMEOUT_EN defined: 8-bit counter cleared on DISPATCH, increments each EXEC_WAIT cycle; reaching 255 without done -> FAULT (fault=1, outputs idle) until rst.
REQ-029 Macro EXEC_TIMEOUT_EN undefined: no counter, EXEC_WAIT waits forever, FAULT unreachable, fault tied 0.

Verification
REQ-030 rst, run=1, memData=16'h1234 ready after 2 wait cycles, aluDone 3 cycles after pulse -> single aluActivate, opcode=1, param1=8, param2=52, instrCount=1.
REQ-031 Sequence 16'hC041, 16'hD082, 16'hE0C3 -> ldActivate, stActivate, brActivate in order, one pulse each, instrCount=3.
REQ-032 memData=16'hF000 -> halted=1, no activate, instrCount unchanged; further memReady ignored.
REQ-033 aluDone held 1 before pulse, stDone pulsed during ALU EXEC_WAIT -> not accepted until aluDone seen from second wait cycle.
REQ-034 rst pulse mid-EXEC_WAIT -> IDLE, instrCount=0 at once (asynchronously).
REQ-035 EXEC_TIMEOUT_EN defined, done never asserted -> fault=1 at 255th EXEC_WAIT cycle; undefined -> fault stays 0.
